// File: rtl/calc_pkg.sv
// calc_pkg: shared command, status and state encodings plus segment helpers for the calculator
package calc_pkg;
  typedef enum logic [3:0] {
    CMD_D0, CMD_D1, CMD_D2, CMD_D3, CMD_D4, CMD_D5, CMD_D6, CMD_D7, CMD_D8, CMD_D9,
    CMD_ADD, CMD_SUB, CMD_MUL, CMD_CE, CMD_EQ, CMD_CA
  } cmd_t;
  typedef enum logic [1:0] {ST_ENTRY, ST_BUSY, ST_ERROR, ST_RESULT} status_t;
  typedef enum logic [2:0] {S_ENTRY_A, S_ENTRY_B, S_CALC, S_CONV, S_SHOW, S_ERROR} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [69:0] SEG_TAB = {7'h6f, 7'h7f, 7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f};
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    return d <= 4'd9 ? SEG_TAB[7*d +: 7] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: sequential double-dabble converter, done pulses exactly W cycles after start
module calc_bin2bcd #(
  parameter int W = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [4*DIGITS-1:0] adj;
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clock) begin
    done <= 1'b0;
    if (reset) begin
      busy <= 1'b0;
      cnt <= '0;
      sh <= '0;
      bcd <= '0;
    end else if (start) begin
      {bcd, sh} <= {(4*DIGITS)'(0), bin} << 1;
      cnt <= CW'(W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt <= cnt - 1'b1;
      busy <= cnt != 1;
      done <= cnt == 1;
    end
  end
endmodule

// File: rtl/calc_engine.sv
// calc_engine: keypad-driven A op B calculator with chaining, overflow detection and seven-segment output
module calc_engine
  import calc_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  cmd_t                    cmd,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [DIGITS-1:0][6:0]  displays,
  output status_t                 status
);
  localparam int W = $clog2(10**DIGITS);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic signed [2*W:0] MAXV = (2*W+1)'(10**DIGITS - 1);
  localparam logic signed [2*W:0] MINV = (2*W+1)'(-(10**(DIGITS-1) - 1));
  state_t state;
  cmd_t op;
  logic [W-1:0] a, b, res, nx, mag;
  logic a_neg, neg, fire, clr, is_dig, is_op, ovf, start, busy, done, seen;
  logic [3:0] d;
  logic [CW-1:0] cnt;
  logic [4*DIGITS-1:0] ent_bcd, res_bcd;
  logic signed [2*W:0] sa, sb, r;
  assign fire = cmd_valid && cmd_ready;
  assign clr = reset || (fire && (cmd == CMD_CA || (state == S_SHOW && cmd == CMD_CE)));
  assign d = cmd;
  assign is_dig = cmd <= CMD_D9;
  assign is_op = cmd inside {CMD_ADD, CMD_SUB, CMD_MUL};
  assign nx = (state == S_ENTRY_B ? b : a) * W'(10) + W'(d);
  assign sa = a_neg ? -$signed({{(W+1){1'b0}}, a}) : $signed({{(W+1){1'b0}}, a});
  assign sb = $signed({{(W+1){1'b0}}, b});
  assign r = op == CMD_ADD ? sa + sb : op == CMD_SUB ? sa - sb : sa * sb;
  assign ovf = r > MAXV || r < MINV;
  assign mag = W'(r < 0 ? -r : r);
  assign start = state == S_CALC && !ovf;
  calc_bin2bcd #(.W(W), .DIGITS(DIGITS)) u_conv (
    .clock(clock), .reset(reset), .start(start), .bin(mag),
    .busy(busy), .done(done), .bcd(res_bcd)
  );
  always_ff @(posedge clock) begin
    if (clr) begin
      state <= S_ENTRY_A;
      op <= CMD_ADD;
      a <= '0;
      a_neg <= 1'b0;
      b <= '0;
      res <= '0;
      neg <= 1'b0;
      cnt <= '0;
      ent_bcd <= '0;
      status <= ST_ENTRY;
      cmd_ready <= 1'b1;
    end else begin
      case (state)
        S_ENTRY_A, S_ENTRY_B: if (fire) begin
          if (is_dig) begin
            if (int'(cnt) < DIGITS && (cnt != '0 || d != 4'd0)) begin
              if (state == S_ENTRY_B) b <= nx;
              else a <= nx;
              ent_bcd <= {ent_bcd[4*DIGITS-5:0], d};
              cnt <= cnt + 1'b1;
            end
          end else if (is_op && (state == S_ENTRY_A || cnt == '0)) begin
            op <= cmd;
            state <= S_ENTRY_B;
            b <= '0;
            ent_bcd <= '0;
            cnt <= '0;
          end else if (cmd == CMD_CE) begin
            if (state == S_ENTRY_B) b <= '0;
            else begin
              a <= '0;
              a_neg <= 1'b0;
            end
            ent_bcd <= '0;
            cnt <= '0;
          end else if (cmd == CMD_EQ && state == S_ENTRY_B) begin
            state <= S_CALC;
            status <= ST_BUSY;
            cmd_ready <= 1'b0;
          end
        end
        S_CALC: begin
          res <= mag;
          neg <= r < 0;
          state <= ovf ? S_ERROR : S_CONV;
          status <= ovf ? ST_ERROR : ST_BUSY;
          cmd_ready <= ovf;
        end
        S_CONV: if (done && !busy) begin
          state <= S_SHOW;
          status <= ST_RESULT;
          cmd_ready <= 1'b1;
        end
        S_SHOW: if (fire && (is_dig || is_op)) begin
          state <= is_dig ? S_ENTRY_A : S_ENTRY_B;
          a <= is_dig ? W'(d) : res;
          a_neg <= is_dig ? 1'b0 : neg;
          op <= is_op ? cmd : op;
          b <= '0;
          neg <= 1'b0;
          cnt <= is_dig ? CW'(d != 4'd0) : '0;
          ent_bcd <= is_dig ? (4*DIGITS)'(d) : '0;
          status <= ST_ENTRY;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    seen = 1'b0;
    displays = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen || res_bcd[4*i +: 4] != 4'd0 || i == 0;
      displays[i] = state == S_ERROR ? (i == 0 ? SEG_E : SEG_BLANK)
                  : state == S_SHOW ? (neg && i == DIGITS - 1 ? SEG_MINUS
                                       : seen ? bcd_to_seg(res_bcd[4*i +: 4]) : SEG_BLANK)
                  : (i < int'(cnt) || i == 0) ? bcd_to_seg(ent_bcd[4*i +: 4]) : SEG_BLANK;
    end
  end
endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed keypad sequences with hand-computed display and status expectations
module tb_calc_engine;
  import calc_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  cmd_t cmd = CMD_D0;
  logic cmd_ready;
  logic [7:0][6:0] displays;
  logic [1:0] status;
  int n_chk = 0;
  int n_pass = 0;
  int n;
  logic rdy;
  calc_engine #(.DIGITS(8)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .displays(displays), .status(status)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [6:0] seg(input byte ch);
    case (ch)
      "0": return 7'h3f;
      "1": return 7'h06;
      "2": return 7'h5b;
      "3": return 7'h4f;
      "4": return 7'h66;
      "5": return 7'h6d;
      "6": return 7'h7d;
      "7": return 7'h07;
      "8": return 7'h7f;
      "9": return 7'h6f;
      "-": return 7'h40;
      "E": return 7'h79;
      default: return 7'h00;
    endcase
  endfunction
  function automatic logic [55:0] dsp(input string s);
    logic [55:0] v;
    for (int i = 0; i < 8; i++) v[7*i +: 7] = seg(s[7-i]);
    return v;
  endfunction
  function automatic cmd_t code(input byte ch);
    return ch == "+" ? CMD_ADD : ch == "-" ? CMD_SUB : ch == "*" ? CMD_MUL :
           ch == "C" ? CMD_CE : ch == "=" ? CMD_EQ : ch == "A" ? CMD_CA : cmd_t'(ch - "0");
  endfunction
  task automatic press(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clock);
      cmd = code(s[i]);
      cmd_valid = 1'b1;
    end
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_busy(output int cycles, output logic ready_seen);
    cycles = 0;
    ready_seen = 1'b0;
    while (status == 2'b01 && cycles < 200) begin
      cycles++;
      ready_seen = ready_seen | cmd_ready;
      @(negedge clock);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_status", status, 2'b00);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_disp", displays, dsp("       0"));
    press("1234+1234=");
    wait_busy(n, rdy);
    chk("add_busy_cycles", n, 28);
    chk("add_ready_busy", rdy, 1'b0);
    chk("add_status", status, 2'b11);
    chk("add_disp", displays, dsp("    2468"));
    press("+2=");
    wait_busy(n, rdy);
    chk("chain_disp", displays, dsp("    2470"));
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      cmd = cmd_t'(i + 7);
    end
    chk("novalid_status", status, 2'b11);
    chk("novalid_disp", displays, dsp("    2470"));
    press("5+-3=");
    wait_busy(n, rdy);
    chk("replace_disp", displays, dsp("       2"));
    press("12-345=");
    wait_busy(n, rdy);
    chk("neg_status", status, 2'b11);
    chk("neg_disp", displays, dsp("-    333"));
    press("99999999*2=");
    wait_busy(n, rdy);
    chk("ovf_busy_cycles", n, 1);
    chk("ovf_status", status, 2'b10);
    chk("ovf_disp", displays, dsp("       E"));
    chk("ovf_ready", cmd_ready, 1'b1);
    press("5");
    chk("err_digit_status", status, 2'b10);
    chk("err_digit_disp", displays, dsp("       E"));
    press("A");
    chk("ca_status", status, 2'b00);
    chk("ca_disp", displays, dsp("       0"));
    press("123456789");
    chk("limit_disp", displays, dsp("12345678"));
    press("C");
    chk("ce_a_disp", displays, dsp("       0"));
    press("7+8C9=");
    wait_busy(n, rdy);
    chk("ce_b_disp", displays, dsp("      16"));
    press("=");
    chk("show_eq_status", status, 2'b11);
    chk("show_eq_disp", displays, dsp("      16"));
    press("C");
    chk("show_ce_status", status, 2'b00);
    chk("show_ce_disp", displays, dsp("       0"));
    press("1+1=");
    repeat (5) @(negedge clock);
    chk("midconv_busy", status, 2'b01);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_status", status, 2'b00);
    chk("midrst_ready", cmd_ready, 1'b1);
    chk("midrst_disp", displays, dsp("       0"));
    repeat (40) @(negedge clock);
    chk("midrst_stale_status", status, 2'b00);
    chk("midrst_stale_disp", displays, dsp("       0"));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
